// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between an
// instruction-fetch requester and a load/store requester. Data accesses have
// priority; a bounded starvation counter guarantees forward progress for fetch.
// Read data returns one cycle after the grant and is steered back to the
// requester that owns the outstanding read.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,

    // fetch requester
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    // load/store requester
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,

    // shared memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter is wide enough to hold STARVE_MAX; never narrower than one bit.
    localparam int CW = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    // Which requester the read issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          starve_hit;

    // Grant selection: data side wins unless fetch has waited its limit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        starve_hit = if_req && (starve_q == STARVE_LIM);
        if (!rst) begin
            if (dm_req && !starve_hit) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Steer the granted requester onto the memory port; fetch is always a read.
    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Next-state for the read owner and the fetch starvation counter.
    always_comb begin
        owner_d  = OWN_NONE;
        starve_d = starve_q;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            owner_d = OWN_DM;
        end

        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its inputs.
        if (rst) begin
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Return path: a read in flight when reset is raised is dropped, so the
    // valids are also masked by rst in the cycle reset is first seen.
    always_comb begin
        if_rvalid = (owner_q == OWN_IF) && !rst;
        dm_rvalid = (owner_q == OWN_DM) && !rst;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a vector table plus hand-written sequences
// drive the requesters; grants are compared per cycle, and read data is
// checked through per-requester scoreboards against a shadow copy of memory.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-on contents shared by the memory model and the shadow copy.
    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 5) return 32'h1234ABCD;
        if (a == 7) return 32'h0BADF00D;
        if (a == 3) return 32'h33333333;
        return {16'hC0DE, 6'b0, a[9:0]};
    endfunction

    // Synchronous single-port memory: read data valid the cycle after.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    typedef struct {
        bit            rst;
        bit            if_req;
        logic [AW-1:0] if_addr;
        bit            dm_req;
        bit            dm_we;
        logic [AW-1:0] dm_addr;
        logic [DW-1:0] dm_wdata;
        bit            exp_if_gnt;
        bit            exp_dm_gnt;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t if_q[$];
    exp_t dm_q[$];
    vec_t vecs[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit ir, input int ia, input bit dr,
                                input bit dw, input int da, input logic [DW-1:0] wd,
                                input bit eig, input bit edg);
        vec_t v;
        v.rst = r;   v.if_req = ir; v.if_addr = AW'(ia);
        v.dm_req = dr; v.dm_we = dw; v.dm_addr = AW'(da); v.dm_wdata = wd;
        v.exp_if_gnt = eig; v.exp_dm_gnt = edg;
        return v;
    endfunction

    // One clock cycle: drive, record expectations, then sample at negedge.
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst = v.rst; if_req = v.if_req; if_addr = v.if_addr;
        dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
        if (v.rst) begin
            if_q.delete();
            dm_q.delete();
        end else if (v.exp_if_gnt) begin
            e.due = cyc + 1; e.data = ref_mem[v.if_addr];
            if_q.push_back(e);
        end else if (v.exp_dm_gnt) begin
            if (v.dm_we) begin
                ref_mem[v.dm_addr] = v.dm_wdata;
            end else begin
                e.due = cyc + 1; e.data = ref_mem[v.dm_addr];
                dm_q.push_back(e);
            end
        end
        @(negedge clk);
        check({tag, ".if_gnt"}, DW'(if_gnt), DW'(v.exp_if_gnt));
        check({tag, ".dm_gnt"}, DW'(dm_gnt), DW'(v.exp_dm_gnt));
        check({tag, ".mem_en"}, DW'(mem_en), DW'(v.exp_if_gnt | v.exp_dm_gnt));
        if (v.exp_if_gnt) begin
            check({tag, ".mem_addr"}, DW'(mem_addr), DW'(v.if_addr));
            check({tag, ".mem_we"},   DW'(mem_we),   '0);
        end
        if (v.exp_dm_gnt) begin
            check({tag, ".mem_addr"}, DW'(mem_addr), DW'(v.dm_addr));
            check({tag, ".mem_we"},   DW'(mem_we),   DW'(v.dm_we));
            if (v.dm_we) check({tag, ".mem_wdata"}, mem_wdata, v.dm_wdata);
        end
        if (if_q.size() > 0 && if_q[0].due == cyc) begin
            check({tag, ".if_rvalid"}, DW'(if_rvalid), 1);
            check({tag, ".if_rdata"},  if_rdata, if_q[0].data);
            void'(if_q.pop_front());
        end else begin
            check({tag, ".if_rvalid"}, DW'(if_rvalid), 0);
            check({tag, ".if_rdata"},  if_rdata, '0);
        end
        if (dm_q.size() > 0 && dm_q[0].due == cyc) begin
            check({tag, ".dm_rvalid"}, DW'(dm_rvalid), 1);
            check({tag, ".dm_rdata"},  dm_rdata, dm_q[0].data);
            void'(dm_q.pop_front());
        end else begin
            check({tag, ".dm_rvalid"}, DW'(dm_rvalid), 0);
            check({tag, ".dm_rdata"},  dm_rdata, '0);
        end
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);

        // Table: reset with requests present, then arbitration patterns.
        //                r  if ia  dm we da  wdata         eig edg
        vecs.push_back(mk(1, 1, 5,  1, 0, 7,  '0,           0, 0));
        vecs.push_back(mk(1, 1, 5,  1, 1, 7,  32'h11111111, 0, 0));
        vecs.push_back(mk(0, 1, 5,  0, 0, 0,  '0,           1, 0)); // fetch only
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  '0,           0, 0));
        vecs.push_back(mk(0, 1, 1,  1, 0, 7,  '0,           0, 1)); // conflict
        vecs.push_back(mk(0, 1, 1,  0, 0, 0,  '0,           1, 0));
        vecs.push_back(mk(0, 0, 0,  1, 1, 20, 32'hCAFEF00D, 0, 1)); // store
        vecs.push_back(mk(0, 0, 0,  1, 0, 20, '0,           0, 1)); // load back
        vecs.push_back(mk(0, 1, 20, 0, 0, 0,  '0,           1, 0));
        vecs.push_back(mk(0, 1, 2,  1, 1, 21, 32'h21212121, 0, 1));
        vecs.push_back(mk(0, 1, 2,  1, 1, 22, 32'h22222222, 0, 1));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  '0,           0, 0)); // clears counter
        vecs.push_back(mk(0, 1, 2,  1, 0, 21, '0,           0, 1));
        vecs.push_back(mk(0, 1, 2,  1, 0, 22, '0,           0, 1));
        vecs.push_back(mk(0, 1, 2,  1, 0, 0,  '0,           0, 1));
        vecs.push_back(mk(0, 1, 2,  1, 0, 0,  '0,           1, 0)); // starve limit
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  '0,           0, 0));
        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

        // Starvation: data side held six cycles against a pending fetch.
        for (int i = 0; i < 6; i++)
            step($sformatf("starve%0d", i), mk(0, 1, 4, 1, 0, 30 + i, '0, i == 3, i != 3));
        step("starve_idle", mk(0, 0, 0, 0, 0, 0, '0, 0, 0));

        // Store then load of the same word, back to back.
        step("sl_store", mk(0, 0, 0, 1, 1, 9, 32'hDEADBEEF, 0, 1));
        step("sl_load",  mk(0, 0, 0, 1, 0, 9, '0, 0, 1));
        step("sl_idle",  mk(0, 0, 0, 0, 0, 0, '0, 0, 0));

        // Reset while a fetch read is in flight: the read is dropped.
        step("rf_fetch", mk(0, 1, 3, 0, 0, 0, '0, 1, 0));
        step("rf_rst",   mk(1, 1, 3, 1, 0, 11, '0, 0, 0));
        step("rf_post0", mk(0, 1, 3, 1, 0, 11, '0, 0, 1));
        step("rf_post1", mk(0, 1, 3, 1, 0, 12, '0, 0, 1));
        step("rf_post2", mk(0, 1, 3, 1, 0, 13, '0, 0, 1)); // counter now at limit
        // Reset with the counter saturated and a load in flight.
        step("rc_rst",   mk(1, 1, 3, 1, 0, 14, '0, 0, 0));
        step("rc_post",  mk(0, 1, 3, 1, 0, 15, '0, 0, 1)); // counter restarted at 0
        step("rc_idle0", mk(0, 0, 0, 0, 0, 0, '0, 0, 0));
        step("rc_idle1", mk(0, 0, 0, 0, 0, 0, '0, 0, 0));

        check("if_scoreboard_empty", DW'(if_q.size()), 0);
        check("dm_scoreboard_empty", DW'(dm_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, memory word-address width (1024 words).
REQ-002 SHALL have parameter DW, default 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, maximum consecutive cycles a pending fetch may be denied.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port if_req  input  1  fetch-stage read request; held until granted.
REQ-007 SHALL have port if_addr  input  AW  fetch word address.
REQ-008 SHALL have port if_gnt  output  1  fetch request accepted this cycle; low acts as fetch stall.
REQ-009 SHALL have port if_rvalid  output  1  if_rdata valid this cycle.
REQ-010 SHALL have port if_rdata  output  DW  fetched instruction word.
REQ-011 SHALL have port dm_req  input  1  memory-stage request; held until granted.
REQ-012 SHALL have port dm_we  input  1  1 = store (SW), 0 = load (LW).
REQ-013 SHALL have port dm_addr  input  AW  data word address.
REQ-014 SHALL have port dm_wdata  input  DW  store data.
REQ-015 SHALL have port dm_gnt  output  1  data request accepted this cycle.
REQ-016 SHALL have port dm_rvalid  output  1  dm_rdata valid this cycle (loads only).
REQ-017 SHALL have port dm_rdata  output  DW  load data.
REQ-018 SHALL have ports mem_en, mem_we (output, 1 bit each), mem_addr (output, AW), mem_wdata (output, DW) and mem_rdata (input, DW), forming the single shared memory port; mem_rdata is valid the cycle after a read with mem_en=1 and mem_we=0.

Function
REQ-019 SHALL assert at most one of if_gnt and dm_gnt per cycle; mem_en SHALL equal if_gnt OR dm_gnt.
REQ-020 SHALL drive the grants combinationally from the requests and the starvation counter, and SHALL mux mem_we, mem_addr and mem_wdata combinationally from the granted requester (mem_we=0 for fetch).
REQ-021 Priority SHALL be: dm_req wins, unless if_req=1 and starve_cnt==STARVE_MAX, in which case if_req wins.
REQ-022 With only one requester active, that requester SHALL be granted in the same cycle.
REQ-023 starve_cnt: cleared on if_gnt or when if_req=0; incremented when if_req=1 and if_gnt=0; saturates at STARVE_MAX; width is clog2(STARVE_MAX+1).
REQ-024 SHALL keep a read-owner register with three states: NONE, IF, DM. It loads IF on if_gnt, DM on dm_gnt with dm_we=0, and NONE otherwise (including store grants and idle cycles).
REQ-025 if_rvalid SHALL be high exactly when owner==IF, and dm_rvalid exactly when owner==DM; read latency is exactly 1 cycle after grant.
REQ-026 if_rdata and dm_rdata SHALL pass mem_rdata through while the matching rvalid is high, and SHALL be 0 otherwise.
REQ-027 Back-to-back grants SHALL be supported every cycle, with no bubble between reads, between writes, or across a read/write turnaround.
REQ-028 A store SHALL produce no rvalid; the store is complete at the grant edge.
REQ-029 Each requester SHALL be granted in request order only; there is no reordering and no outstanding depth beyond 1.
REQ-030 When dm_req is held continuously with if_req=1, the fetch SHALL be granted within STARVE_MAX+1 cycles.

Reset
REQ-031 When rst=1 at a clock edge: owner←NONE, starve_cnt←0; in the following cycle if_rvalid=dm_rvalid=0 and both rdata outputs are 0.
REQ-032 While rst=1, if_gnt, dm_gnt and mem_en SHALL be 0 regardless of requests; a read pending at reset assertion SHALL be dropped with no rvalid.
REQ-033 On the first cycle after rst deasserts, the arbiter SHALL accept requests per REQ-021 with starve_cnt=0.

Verification
REQ-034 Fetch only: if_req=1, if_addr=5, memory word 5=0x1234ABCD -> if_gnt=1 in the same cycle; next cycle if_rvalid=1 and if_rdata=0x1234ABCD; dm_rvalid=0.
REQ-035 Conflict: if_req=dm_req=1, dm_we=0, dm_addr=7 -> dm_gnt=1, if_gnt=0; next cycle dm_rvalid=1 with word 7 and starve_cnt=1.
REQ-036 Starvation: dm_req held at 1 for 6 cycles with if_req=1 (STARVE_MAX=3) -> dm_gnt on cycles 0-2, if_gnt on cycle 3, dm_gnt on cycles 4-5.
REQ-037 Store then load: cycle 0 store 0xDEADBEEF to address 9, cycle 1 load address 9 -> dm_rvalid=0 in cycle 1; cycle 2 dm_rvalid=1 with dm_rdata=0xDEADBEEF.
REQ-038 Reset mid-read: if_gnt for address 3 in cycle 0, rst=1 in cycle 1 -> if_rvalid=0 in cycle 1; all grants are 0 while rst=1; starve_cnt=0 after reset.
